// File: rtl/lib_mux_fifo_n.sv
// lib_mux_fifo_n: NUM_CH valid/ready ingress channels, each with a private
// DEPTH-entry FIFO, merged onto one valid/ready output by a round-robin arbiter.
// The arbiter holds its grant under backpressure and, with PKT_MODE=1, keeps
// a packet contiguous from its first beat until the beat carrying last=1.
module lib_mux_fifo_n #(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 4,
    parameter int NUM_BITS  = 32,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int PKT_MODE  = 0,
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_CH-1:0]                  in_val_i,
    input  logic [NUM_CH-1:0][NUM_BITS-1:0]    in_d_i,
    input  logic [NUM_CH-1:0]                  in_last_i,
    output logic [NUM_CH-1:0]                  in_rdy_o,
    output logic                               out_val_o,
    output logic [NUM_BITS-1:0]                out_d_o,
    output logic                               out_last_o,
    output logic [CHW-1:0]                     out_ch_o,
    input  logic                               out_rdy_i,
    output logic [NUM_CH-1:0][LW-1:0]          level_o,
    output logic [NUM_CH-1:0]                  afull_o
);

    logic [NUM_CH-1:0]                 empty;
    logic [NUM_CH-1:0]                 pop;
    logic [NUM_CH-1:0][NUM_BITS-1:0]   head_d;
    logic [NUM_CH-1:0]                 head_last;

    // Arbiter state: priority pointer, backpressure hold, packet lock
    logic [CHW-1:0] p_q, p_d;
    logic           hold_q, hold_d;
    logic [CHW-1:0] hold_ch_q, hold_ch_d;
    logic           lock_q, lock_d;
    logic [CHW-1:0] lock_ch_q, lock_ch_d;

    logic [CHW-1:0] rr_ch;
    logic           rr_found;
    logic [CHW-1:0] gnt;
    logic           hs;

    // Per-channel FIFOs; a channel pops only on a handshake while granted
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign pop[c] = hs && (gnt == CHW'(c));

        lib_mux_fifo_n_ch #(
            .DEPTH     (DEPTH),
            .NUM_BITS  (NUM_BITS),
            .AFULL_LVL (AFULL_LVL),
            .LW        (LW)
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .push_val_i  (in_val_i[c]),
            .push_d_i    (in_d_i[c]),
            .push_last_i (in_last_i[c]),
            .pop_i       (pop[c]),
            .rdy_o       (in_rdy_o[c]),
            .empty_o     (empty[c]),
            .head_d_o    (head_d[c]),
            .head_last_o (head_last[c]),
            .level_o     (level_o[c]),
            .afull_o     (afull_o[c])
        );
    end

    // Round-robin candidate: first non-empty channel at or after p_q (mod NUM_CH)
    always_comb begin
        int idx;
        idx      = 0;
        rr_ch    = p_q;
        rr_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(p_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!rr_found && !empty[idx]) begin
                rr_found = 1'b1;
                rr_ch    = CHW'(idx);
            end
        end
    end

    // Output process: lock beats hold beats the free-running candidate
    always_comb begin
        if (lock_q)      gnt = lock_ch_q;
        else if (hold_q) gnt = hold_ch_q;
        else             gnt = rr_ch;
        out_val_o  = !empty[gnt];
        out_d_o    = head_d[gnt];
        out_last_o = head_last[gnt];
        out_ch_o   = gnt;
        hs         = out_val_o && out_rdy_i;
    end

    // Next-state process for pointer, hold and lock
    always_comb begin
        p_d       = p_q;
        hold_d    = out_val_o && !out_rdy_i;
        hold_ch_d = gnt;
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (hs) begin
            p_d = (gnt == CHW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
            if (PKT_MODE != 0) begin
                lock_d    = !out_last_o;
                lock_ch_d = gnt;
            end
        end
    end

    // State register process
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q       <= '0;
            hold_q    <= 1'b0;
            hold_ch_q <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            p_q       <= p_d;
            hold_q    <= hold_d;
            hold_ch_q <= hold_ch_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

endmodule

// One channel's circular buffer with registered occupancy. The head entry is
// read combinationally from storage, so a push is visible one cycle later.
module lib_mux_fifo_n_ch #(
    parameter int DEPTH     = 4,
    parameter int NUM_BITS  = 32,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int LW        = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_val_i,
    input  logic [NUM_BITS-1:0] push_d_i,
    input  logic                push_last_i,
    input  logic                pop_i,
    output logic                rdy_o,
    output logic                empty_o,
    output logic [NUM_BITS-1:0] head_d_o,
    output logic                head_last_o,
    output logic [LW-1:0]       level_o,
    output logic                afull_o
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LWP1 = LW + 1;
    localparam logic [LW:0] AF_LVL = LWP1'(AFULL_LVL);

    typedef struct packed {
        logic                last;
        logic [NUM_BITS-1:0] data;
    } beat_t;

    beat_t          mem_q [DEPTH];
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
        return (v == PW'(DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    // Full blocks pushes even when the same cycle pops
    assign rdy_o       = (level_q != LW'(DEPTH));
    assign empty_o     = (level_q == '0);
    assign push        = push_val_i && rdy_o;
    assign pop         = pop_i && !empty_o;
    assign level_o     = level_q;
    assign head_d_o    = mem_q[rptr_q].data;
    assign head_last_o = mem_q[rptr_q].last;

    if (AFULL_LVL <= 0) begin : g_af_const
        assign afull_o = 1'b1;
    end else begin : g_af_cmp
        assign afull_o = ({1'b0, level_q} >= AF_LVL);
    end

    // Pointer and occupancy next state
    always_comb begin
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
        end
    end

    // Payload storage; contents are meaningless while level is zero
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= '{last: push_last_i, data: push_d_i};
    end

endmodule

// File: tb/tb_lib_mux_fifo_n.sv
// Bench for lib_mux_fifo_n: two instances (PKT_MODE 0 and 1) share inputs and
// are compared against a queue-based model of the buffering and arbitration.
module tb_lib_mux_fifo_n;

    localparam int NCH = 4;
    localparam int DEP = 4;
    localparam int NB  = 32;
    localparam int LW  = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NCH-1:0]            in_val;
    logic [NCH-1:0][NB-1:0]    in_d;
    logic [NCH-1:0]            in_last;
    logic                      out_rdy;

    logic [NCH-1:0]            o_rdy  [2];
    logic                      o_val  [2];
    logic [NB-1:0]             o_d    [2];
    logic                      o_last [2];
    logic [1:0]                o_ch   [2];
    logic [NCH-1:0][LW-1:0]    o_lvl  [2];
    logic [NCH-1:0]            o_af   [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lib_mux_fifo_n #(.NUM_CH(NCH), .DEPTH(DEP), .NUM_BITS(NB), .PKT_MODE(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_val_i(in_val), .in_d_i(in_d), .in_last_i(in_last),
        .in_rdy_o(o_rdy[0]), .out_val_o(o_val[0]), .out_d_o(o_d[0]), .out_last_o(o_last[0]),
        .out_ch_o(o_ch[0]), .out_rdy_i(out_rdy), .level_o(o_lvl[0]), .afull_o(o_af[0])
    );

    lib_mux_fifo_n #(.NUM_CH(NCH), .DEPTH(DEP), .NUM_BITS(NB), .PKT_MODE(1)) u_pkt (
        .clk_i(clk), .rst_i(rst), .in_val_i(in_val), .in_d_i(in_d), .in_last_i(in_last),
        .in_rdy_o(o_rdy[1]), .out_val_o(o_val[1]), .out_d_o(o_d[1]), .out_last_o(o_last[1]),
        .out_ch_o(o_ch[1]), .out_rdy_i(out_rdy), .level_o(o_lvl[1]), .afull_o(o_af[1])
    );

    // Reference model: index 0 = plain round robin, index 1 = packet lock
    logic [NB:0]            mq [2][NCH][$];
    int                     mp [2];
    bit                     mhold [2];
    int                     mholdch [2];
    bit                     mlock [2];
    int                     mlockch [2];

    logic                   e_val  [2];
    logic [1:0]             e_ch   [2];
    logic [NB-1:0]          e_d    [2];
    logic                   e_last [2];
    logic [NCH-1:0][LW-1:0] e_lvl  [2];
    logic [NCH-1:0]         e_rdy  [2];
    logic [NCH-1:0]         e_af   [2];

    function automatic void model_eval();
        for (int m = 0; m < 2; m++) begin
            int g;
            bit found;
            g = mp[m];
            found = 0;
            if (mlock[m]) g = mlockch[m];
            else if (mhold[m]) g = mholdch[m];
            else begin
                for (int i = 0; i < NCH; i++) begin
                    if (!found && mq[m][(mp[m] + i) % NCH].size() != 0) begin
                        found = 1;
                        g = (mp[m] + i) % NCH;
                    end
                end
            end
            e_val[m] = (mq[m][g].size() != 0);
            e_ch[m]  = 2'(g);
            if (e_val[m]) {e_last[m], e_d[m]} = mq[m][g][0];
            else          {e_last[m], e_d[m]} = '0;
            for (int c = 0; c < NCH; c++) begin
                e_lvl[m][c] = 3'(mq[m][c].size());
                e_rdy[m][c] = (mq[m][c].size() != DEP);
                e_af[m][c]  = (mq[m][c].size() >= DEP - 1);
            end
        end
    endfunction

    function automatic void model_clock();
        for (int m = 0; m < 2; m++) begin
            bit acc [NCH];
            if (rst) begin
                for (int c = 0; c < NCH; c++) mq[m][c].delete();
                mp[m] = 0; mhold[m] = 0; mholdch[m] = 0; mlock[m] = 0; mlockch[m] = 0;
            end else begin
                for (int c = 0; c < NCH; c++) acc[c] = in_val[c] && (mq[m][c].size() < DEP);
                if (e_val[m] && out_rdy) begin
                    void'(mq[m][e_ch[m]].pop_front());
                    mp[m] = (int'(e_ch[m]) + 1) % NCH;
                    if (m == 1) begin
                        mlock[m]   = !e_last[m];
                        mlockch[m] = int'(e_ch[m]);
                    end
                end
                mhold[m]   = e_val[m] && !out_rdy;
                mholdch[m] = int'(e_ch[m]);
                for (int c = 0; c < NCH; c++)
                    if (acc[c]) mq[m][c].push_back({in_last[c], in_d[c]});
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_clock();
        #1;
        model_eval();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_val = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_val = '0; in_d = '0; in_last = '0; out_rdy = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_lvl[m] !== '0) begin n_fail++; $display("FAIL reset_level m%0d: got %h want 0", m, o_lvl[m]); end
            n_chk++; if (o_af[m] !== 4'h0) begin n_fail++; $display("FAIL reset_afull m%0d: got %h want 0", m, o_af[m]); end
            n_chk++; if (o_rdy[m] !== 4'hF) begin n_fail++; $display("FAIL reset_in_rdy m%0d: got %h want f", m, o_rdy[m]); end
            n_chk++; if (o_val[m] !== 1'b0) begin n_fail++; $display("FAIL reset_out_val m%0d: got %b want 0", m, o_val[m]); end
        end
    endtask

    task automatic test_single_beat();
        in_val = 4'b0100; in_d[2] = 32'hA5; in_last = 4'hF; out_rdy = 1'b1;
        cyc();
        in_val = '0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_val[m] !== 1'b1 || o_d[m] !== 32'hA5 || o_ch[m] !== 2'd2)
                begin n_fail++; $display("FAIL single_out m%0d: got val %b d %h ch %0d want 1 a5 2", m, o_val[m], o_d[m], o_ch[m]); end
            n_chk++; if (o_lvl[m][2] !== 3'd1 || o_rdy[m] !== 4'hF)
                begin n_fail++; $display("FAIL single_lvl1 m%0d: got lvl %0d rdy %h want 1 f", m, o_lvl[m][2], o_rdy[m]); end
        end
        cyc();
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_lvl[m][2] !== 3'd0 || o_val[m] !== 1'b0 || o_rdy[m] !== 4'hF)
                begin n_fail++; $display("FAIL single_drain m%0d: got lvl %0d val %b rdy %h want 0 0 f", m, o_lvl[m][2], o_val[m], o_rdy[m]); end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        out_rdy = 1'b0; in_last = 4'hF;
        for (int b = 0; b < 3; b++) begin
            in_val = 4'hF;
            for (int c = 0; c < NCH; c++) in_d[c] = 32'(32'h100 * c + b);
            cyc();
        end
        in_val = '0; out_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int m = 0; m < 2; m++) begin
                n_chk++; if (o_val[m] !== 1'b1 || o_ch[m] !== 2'(i % 4) || o_d[m] !== 32'(32'h100 * (i % 4) + i / 4))
                    begin n_fail++; $display("FAIL fair_seq[%0d] m%0d: got val %b ch %0d d %h want 1 %0d %h", i, m, o_val[m], o_ch[m], o_d[m], i % 4, 32'h100 * (i % 4) + i / 4); end
            end
            cyc();
        end
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_val[m] !== 1'b0) begin n_fail++; $display("FAIL fair_empty m%0d: got %b want 0", m, o_val[m]); end
        end
    endtask

    task automatic test_full_backpressure();
        int lvl;
        do_reset();
        out_rdy = 1'b0; in_last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            in_val = 4'b0001; in_d[0] = 32'(32'hB0 + k);
            cyc();
            lvl = (k + 1 > DEP) ? DEP : k + 1;
            for (int m = 0; m < 2; m++) begin
                n_chk++; if (o_lvl[m][0] !== 3'(lvl) || o_af[m][0] !== (lvl >= 3) || o_rdy[m][0] !== (lvl != DEP))
                    begin n_fail++; $display("FAIL full_fill[%0d] m%0d: got lvl %0d af %b rdy %b want %0d %b %b", k, m, o_lvl[m][0], o_af[m][0], o_rdy[m][0], lvl, lvl >= 3, lvl != DEP); end
                n_chk++; if (o_d[m] !== 32'hB0) begin n_fail++; $display("FAIL full_head[%0d] m%0d: got %h want b0", k, m, o_d[m]); end
            end
        end
        in_val = 4'b0010; in_d[1] = 32'hC1;
        cyc();
        in_val = '0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_val[m] !== 1'b1 || o_ch[m] !== 2'd0 || o_d[m] !== 32'hB0 || o_lvl[m][1] !== 3'd1)
                begin n_fail++; $display("FAIL full_hold m%0d: got val %b ch %0d d %h lvl1 %0d want 1 0 b0 1", m, o_val[m], o_ch[m], o_d[m], o_lvl[m][1]); end
        end
    endtask

    task automatic test_full_pushpop();
        logic [NB-1:0] exp_d [3];
        do_reset();
        out_rdy = 1'b0; in_last = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_val = 4'b0001; in_d[0] = 32'(32'hD0 + k);
            cyc();
        end
        in_val = 4'b0001; in_d[0] = 32'hE0; out_rdy = 1'b1;
        cyc();
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_lvl[m][0] !== 3'd3 || o_d[m] !== 32'hD1)
                begin n_fail++; $display("FAIL pp_full m%0d: got lvl %0d d %h want 3 d1", m, o_lvl[m][0], o_d[m]); end
        end
        in_d[0] = 32'hD4;
        cyc();
        in_val = '0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_lvl[m][0] !== 3'd3) begin n_fail++; $display("FAIL pp_both m%0d: got lvl %0d want 3", m, o_lvl[m][0]); end
        end
        exp_d = '{32'hD2, 32'hD3, 32'hD4};
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < 2; m++) begin
                n_chk++; if (o_val[m] !== 1'b1 || o_d[m] !== exp_d[i])
                    begin n_fail++; $display("FAIL pp_drain[%0d] m%0d: got val %b d %h want 1 %h", i, m, o_val[m], o_d[m], exp_d[i]); end
            end
            cyc();
        end
    endtask

    task automatic test_packet_lock();
        logic [1:0]    ch_exp [2][4];
        logic [NB-1:0] d_exp  [2][4];
        do_reset();
        in_val = 4'b0001; in_d[0] = 32'h11; in_last = 4'hF; out_rdy = 1'b1;
        cyc();
        in_val = '0;
        cyc();
        out_rdy = 1'b0;
        in_val = 4'b0011; in_d[0] = 32'h01; in_d[1] = 32'h21; in_last = 4'b1101;
        cyc();
        in_val = 4'b0010; in_d[1] = 32'h22;
        cyc();
        in_d[1] = 32'h23; in_last = 4'hF;
        cyc();
        in_val = '0; out_rdy = 1'b1;
        ch_exp = '{'{2'd1, 2'd0, 2'd1, 2'd1}, '{2'd1, 2'd1, 2'd1, 2'd0}};
        d_exp  = '{'{32'h21, 32'h01, 32'h22, 32'h23}, '{32'h21, 32'h22, 32'h23, 32'h01}};
        for (int i = 0; i < 4; i++) begin
            for (int m = 0; m < 2; m++) begin
                n_chk++; if (o_val[m] !== 1'b1 || o_ch[m] !== ch_exp[m][i] || o_d[m] !== d_exp[m][i])
                    begin n_fail++; $display("FAIL pkt_seq[%0d] m%0d: got val %b ch %0d d %h want 1 %0d %h", i, m, o_val[m], o_ch[m], o_d[m], ch_exp[m][i], d_exp[m][i]); end
            end
            cyc();
        end
        in_val = 4'b0011; in_d[0] = 32'h02; in_d[1] = 32'h31; in_last = 4'b1101;
        cyc();
        in_val = '0; in_last = 4'hF;
        n_chk++; if (o_val[1] !== 1'b1 || o_ch[1] !== 2'd1 || o_d[1] !== 32'h31)
            begin n_fail++; $display("FAIL pkt_first: got val %b ch %0d d %h want 1 1 31", o_val[1], o_ch[1], o_d[1]); end
        cyc();
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_val[1] !== 1'b0) begin n_fail++; $display("FAIL pkt_gap[%0d]: got val %b ch %0d want 0", k, o_val[1], o_ch[1]); end
            if (k == 1) begin in_val = 4'b0010; in_d[1] = 32'h32; end
            cyc();
        end
        in_val = '0;
        n_chk++; if (o_val[1] !== 1'b1 || o_ch[1] !== 2'd1 || o_d[1] !== 32'h32)
            begin n_fail++; $display("FAIL pkt_resume: got val %b ch %0d d %h want 1 1 32", o_val[1], o_ch[1], o_d[1]); end
        cyc();
        n_chk++; if (o_val[1] !== 1'b1 || o_ch[1] !== 2'd0 || o_d[1] !== 32'h02)
            begin n_fail++; $display("FAIL pkt_unlock: got val %b ch %0d d %h want 1 0 02", o_val[1], o_ch[1], o_d[1]); end
        cyc();
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1; in_val = 4'b0111; in_last = 4'b0101;
        for (int c = 0; c < NCH; c++) in_d[c] = 32'(32'h40 + c);
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_val = '0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_lvl[m] !== '0 || o_val[m] !== 1'b0 || o_rdy[m] !== 4'hF)
                begin n_fail++; $display("FAIL rstmid_clear m%0d: got lvl %h val %b rdy %h want 0 0 f", m, o_lvl[m], o_val[m], o_rdy[m]); end
        end
        in_val = 4'b1010; in_d[3] = 32'h55; in_d[1] = 32'h66; in_last = 4'hF;
        cyc();
        in_val = '0;
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_val[m] !== 1'b1 || o_ch[m] !== 2'd1 || o_d[m] !== 32'h66)
                begin n_fail++; $display("FAIL rstmid_first m%0d: got val %b ch %0d d %h want 1 1 66", m, o_val[m], o_ch[m], o_d[m]); end
        end
        cyc();
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (o_val[m] !== 1'b1 || o_ch[m] !== 2'd3 || o_d[m] !== 32'h55)
                begin n_fail++; $display("FAIL rstmid_second m%0d: got val %b ch %0d d %h want 1 3 55", m, o_val[m], o_ch[m], o_d[m]); end
        end
        cyc();
    endtask

    task automatic test_random();
        int pct;
        for (int i = 0; i < 1200; i++) begin
            pct = ((i / 150) % 3 == 0) ? 20 : (((i / 150) % 3 == 1) ? 60 : 95);
            rst     = ($urandom_range(0, 199) == 0);
            in_val  = 4'($urandom);
            in_last = 4'($urandom);
            for (int c = 0; c < NCH; c++) in_d[c] = $urandom;
            out_rdy = ($urandom_range(0, 99) < pct);
            cyc();
            for (int m = 0; m < 2; m++) begin
                n_chk++;
                if (o_val[m] !== e_val[m] || o_lvl[m] !== e_lvl[m] || o_rdy[m] !== e_rdy[m] || o_af[m] !== e_af[m] ||
                    (e_val[m] && (o_d[m] !== e_d[m] || o_last[m] !== e_last[m] || o_ch[m] !== e_ch[m]))) begin
                    n_fail++;
                    $display("FAIL random[%0d] m%0d: got val %b ch %0d d %h last %b lvl %h rdy %h af %h want %b %0d %h %b %h %h %h",
                             i, m, o_val[m], o_ch[m], o_d[m], o_last[m], o_lvl[m], o_rdy[m], o_af[m],
                             e_val[m], e_ch[m], e_d[m], e_last[m], e_lvl[m], e_rdy[m], e_af[m]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_val = '0; in_d = '0; in_last = '0; out_rdy = 1'b0;
        model_eval();
        test_reset();
        test_single_beat();
        test_fairness();
        test_full_backpressure();
        test_full_pushpop();
        test_packet_lock();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lib_mux_fifo_n.md
# lib_mux_fifo_n

Multi-channel ingress buffer and round-robin merger for the AXI infrastructure library: NUM_CH independent valid/ready input channels each feed a private DEPTH-entry FIFO, and a fair arbiter drains them onto one valid/ready output tagged with the source channel ID. It generalises the single-channel n-stage FIFO and the round-robin arbiter into one block. It adds per-channel fill levels, almost-full flags, output stability under backpressure, and an optional packet-lock mode that keeps multi-beat bursts contiguous.

## Interface
- NUM_CH, 4, number of input channels (>=1); CHW = max(1, $clog2(NUM_CH))
- DEPTH, 4, entries per channel FIFO (>=1, any integer, not restricted to powers of 2); LW = $clog2(DEPTH+1)
- NUM_BITS, 32, payload width
- AFULL_LVL, DEPTH-1, afull[c] asserts when level[c] >= AFULL_LVL
- PKT_MODE, 0, 1 = hold grant on a channel from its first beat until a beat with last=1
- clk  input  1  clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_val  input  NUM_CH  per-channel valid
- in_d  input  NUM_CH x NUM_BITS  per-channel payload
- in_last  input  NUM_CH  per-channel end-of-packet; stored with the payload
- in_rdy  output  NUM_CH  per-channel ready
- out_val  output  1  merged valid
- out_d  output  NUM_BITS  merged payload
- out_last  output  1  last flag of the presented beat
- out_ch  output  CHW  source channel of the presented beat
- out_rdy  input  1  downstream ready
- level  output  NUM_CH x LW  per-channel occupancy, 0..DEPTH
- afull  output  NUM_CH  per-channel almost-full

## Operation
- Per channel c: circular buffer with rptr and wptr, wrapping DEPTH-1 -> 0, plus a registered count level[c].
- in_rdy[c] = (level[c] != DEPTH). A push happens when in_val[c] && in_rdy[c]. A full FIFO never accepts a push, including in a cycle where it is popped.
- Push without pop: level +1. Pop without push: level -1. Push and pop in the same cycle: level unchanged.
- Arbiter priority:
  - A priority pointer p starts at 0.
  - The candidate is the first non-empty channel at or after p, searching modulo NUM_CH.
  - On each output handshake (out_val && out_rdy) from channel g, p becomes (g+1) mod NUM_CH.
- Hold rule: if out_val && !out_rdy, the presented channel is registered and stays granted until the handshake. out_d, out_last and out_ch stay stable during this time, even if a higher-priority channel becomes non-empty.
- Packet lock (PKT_MODE=1):
  - A handshake with out_last=0 locks the grant to that channel.
  - The lock clears on a handshake with out_last=1.
  - While locked and that channel is empty, out_val=0 and no other channel is served.
  - With PKT_MODE=0 the out_last value is passed through and ignored by the arbiter.
- out_val = 1 when the granted channel is non-empty. out_d, out_last and out_ch come from that channel's head entry. When out_val=0, these outputs are don't-care.
- Reset mid-operation discards all FIFO contents, the hold state and the lock. In-flight beats are lost by design.

## Timing
- Values after the reset edge:
  - level = 0, afull = 0 (or all ones if AFULL_LVL=0), in_rdy = all ones
  - out_val = 0, p = 0, hold cleared, lock cleared
- Write-to-read latency is 1 cycle: a push into an empty FIFO at edge N gives out_val=1 from cycle N+1 when that channel wins. There is no combinational in->out path.
- in_rdy, level and afull are functions of registered state only, with no combinational dependency on in_val or out_rdy.
- out_val, out_d and out_ch depend combinationally on registered state only. out_rdy affects only the next-state logic.
- Throughput is 1 beat/cycle at the output, and 1 beat/cycle/channel at the inputs while not full.
- DEPTH=1: each channel alternates full and empty. level toggles 0/1 and the channel sustains 1 beat per 2 cycles when popped and pushed in alternating cycles.

## Test plan
- Reset then single beat: NUM_CH=4, DEPTH=4. Push 0xA5 on ch2 at cycle 1 -> out_val=1, out_d=0xA5, out_ch=2 at cycle 2; level[2] goes 1 -> 0 after the handshake; in_rdy all ones throughout.
- Fairness: all 4 channels preloaded with 3 beats, out_rdy=1 -> out_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3, then out_val=0.
- Full/backpressure: out_rdy=0, push 4 beats on ch0 -> level[0]=4, in_rdy[0]=0, afull[0]=1 from level 3. A 5th in_val is not accepted. out_d holds the first beat unchanged while ch1 becomes non-empty.
- Simultaneous push/pop on a full FIFO: level[0]=4, in_val[0]=1, out_rdy=1 -> pop only, level 3. The next cycle a push and pop together keep level at 3.
- Packet lock: PKT_MODE=1. ch1 holds a 3-beat packet (last on beat 3), ch0 holds 1 beat, p=1 -> out_ch 1,1,1 then 0. Delaying ch1's beat 2 by 2 cycles gives out_val=0 for those 2 cycles with no ch0 beat issued.
- Reset mid-operation: assert rst for 1 cycle with all FIFOs partially full and the lock set -> next cycle level=0, out_val=0, in_rdy all ones. A new push is delivered with latency 1 and p=0 priority.
